// File: rtl/instr_fetch.sv
// Fetch stage: sequences the PC, reads the synchronous instruction ROM and hands each
// word to the controller through a valid/ready instruction register.
module instr_fetch #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 7,
  parameter bit          HALT_EN = 1'b1,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] PcAddr,
  output logic              PcUp,
  output logic              PcClr,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [DATA_W-1:0] RomData,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] IrAddr,
  output logic              IrValid,
  input  logic              IrReady,
  output logic              Halted
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StCapture,
    StHold,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   ir_addr_q, ir_addr_d;
  logic                ir_valid_q, ir_valid_d;
  logic                halted_q, halted_d;
  logic                accept;
  logic                halt;

  assign RomAddr = PcAddr;
  assign IR      = ir_q;
  assign IrAddr  = ir_addr_q;
  assign IrValid = ir_valid_q;
  assign Halted  = halted_q;

  assign accept = ir_valid_q & IrReady;
  // The last-address halt keeps a saturated PC from refetching the final word.
  assign halt   = (HALT_EN && (ir_q[DATA_W-1 -: 4] == HALT_OP)) || (ir_addr_q == LastAddr);

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_addr_d  = ir_addr_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    PcUp       = 1'b0;
    PcClr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) state_d = StClear;
      end
      StClear: begin
        PcUp    = 1'b1;
        PcClr   = 1'b1;
        state_d = StIssue;
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        ir_d       = RomData;
        ir_addr_d  = PcAddr;
        ir_valid_d = 1'b1;
        PcUp       = 1'b1;
        state_d    = StHold;
      end
      StHold: begin
        if (accept) begin
          ir_valid_d = 1'b0;
          if (halt) begin
            state_d  = StDone;
            halted_d = 1'b1;
          end else begin
            state_d  = StIssue;
          end
        end
      end
      StDone: begin
        if (Start) begin
          state_d  = StClear;
          halted_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides Start and the handshake; IR and IrAddr keep their last value.
    if (Flush) begin
      state_d    = StIdle;
      ir_valid_d = 1'b0;
      halted_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      ir_q       <= '0;
      ir_addr_q  <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_addr_q  <= ir_addr_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural saturating PC and synchronous ROM;
// a second instance with HALT_EN=0 walks the full address range.
module tb_instr_fetch;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 7;

  logic          Clk;
  logic          Reset;
  logic          Start, Flush, IrReady;
  logic [AW-1:0] PcAddr = 7'd50;
  logic [AW-1:0] RomAddr, IrAddr;
  logic          PcUp, PcClr, IrValid, Halted;
  logic [DW-1:0] RomData, IR;

  logic          Start2, IrReady2;
  logic [AW-1:0] PcAddr2 = 7'd33;
  logic [AW-1:0] RomAddr2, IrAddr2;
  logic          PcUp2, PcClr2, IrValid2, Halted2;
  logic [DW-1:0] RomData2, IR2;

  logic [DW-1:0] mem [128];
  int total = 0;
  int bad   = 0;

  instr_fetch #(.DATA_W(DW), .ADDR_W(AW), .HALT_EN(1'b1), .HALT_OP(4'hF)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Flush(Flush), .PcAddr(PcAddr),
    .PcUp(PcUp), .PcClr(PcClr), .RomAddr(RomAddr), .RomData(RomData), .IR(IR),
    .IrAddr(IrAddr), .IrValid(IrValid), .IrReady(IrReady), .Halted(Halted)
  );

  instr_fetch #(.DATA_W(DW), .ADDR_W(AW), .HALT_EN(1'b0), .HALT_OP(4'hF)) u_dut_nh (
    .Clk(Clk), .Reset(Reset), .Start(Start2), .Flush(1'b0), .PcAddr(PcAddr2),
    .PcUp(PcUp2), .PcClr(PcClr2), .RomAddr(RomAddr2), .RomData(RomData2), .IR(IR2),
    .IrAddr(IrAddr2), .IrValid(IrValid2), .IrReady(IrReady2), .Halted(Halted2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Saturating PC with clear, plus one-cycle-latency ROM, for each instance.
  always @(posedge Clk) begin
    if (PcUp && PcClr) PcAddr <= '0;
    else if (PcUp && PcAddr != 7'd127) PcAddr <= PcAddr + 7'd1;
    RomData <= mem[RomAddr];
    if (PcUp2 && PcClr2) PcAddr2 <= '0;
    else if (PcUp2 && PcAddr2 != 7'd127) PcAddr2 <= PcAddr2 + 7'd1;
    RomData2 <= mem[RomAddr2];
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    total++;
    if ({IR, IrAddr, IrValid, Halted, PcUp, PcClr} !== {16'h0, 7'd0, 4'b0000}) begin
      bad++;
      $display("FAIL reset: IR=%h IrAddr=%0d V=%b H=%b Up=%b Clr=%b want all 0",
               IR, IrAddr, IrValid, Halted, PcUp, PcClr);
    end
    Reset = 1'b0;
    tick;
  endtask

  task automatic test_first_fetch;
    Start = 1'b1;
    tick;  // CLEAR
    Start = 1'b0;
    total++;
    if ({PcClr, PcUp, IrValid} !== 3'b110) begin
      bad++;
      $display("FAIL clear_pulse: Clr/Up/V=%b%b%b want 110", PcClr, PcUp, IrValid);
    end
    tick;  // ISSUE
    total++;
    if ({PcClr, PcUp} !== 2'b00 || PcAddr !== 7'd0 || RomAddr !== 7'd0) begin
      bad++;
      $display("FAIL issue: Clr/Up=%b%b pc=%0d RomAddr=%0d want 00 0 0",
               PcClr, PcUp, PcAddr, RomAddr);
    end
    tick;  // CAPTURE
    total++;
    if ({IrValid, PcUp} !== 2'b01) begin
      bad++;
      $display("FAIL capture: V/Up=%b%b want 01", IrValid, PcUp);
    end
    tick;  // HOLD, fourth edge after Start
    total++;
    if (IrValid !== 1'b1 || IR !== 16'h1234 || IrAddr !== 7'd0 || PcAddr !== 7'd1 ||
        PcUp !== 1'b0) begin
      bad++;
      $display("FAIL first_ir: V=%b IR=%h addr=%0d pc=%0d Up=%b want 1 1234 0 1 0",
               IrValid, IR, IrAddr, PcAddr, PcUp);
    end
  endtask

  task automatic test_stall;
    IrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if ({IrValid, IR, IrAddr, PcUp, PcAddr} !== {1'b1, 16'h1234, 7'd0, 1'b0, 7'd1}) begin
        bad++;
        $display("FAIL stall_%0d: V=%b IR=%h addr=%0d Up=%b pc=%0d want 1 1234 0 0 1",
                 i, IrValid, IR, IrAddr, PcUp, PcAddr);
      end
    end
    IrReady = 1'b1;
    tick;  // accept -> ISSUE
    IrReady = 1'b0;
    total++;
    if (IrValid !== 1'b0) begin
      bad++;
      $display("FAIL accept_drop: V=%b want 0", IrValid);
    end
    tick;
    tick;
    total++;
    if (IrValid !== 1'b1 || IR !== 16'hABCD || IrAddr !== 7'd1 || PcAddr !== 7'd2) begin
      bad++;
      $display("FAIL second_ir: V=%b IR=%h addr=%0d pc=%0d want 1 abcd 1 2",
               IrValid, IR, IrAddr, PcAddr);
    end
  endtask

  task automatic test_halt;
    IrReady = 1'b1;
    repeat (6) tick;
    total++;
    if (IrValid !== 1'b1 || IR !== 16'hF000 || IrAddr !== 7'd3 || Halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_word: V=%b IR=%h addr=%0d H=%b want 1 f000 3 0",
               IrValid, IR, IrAddr, Halted);
    end
    tick;
    IrReady = 1'b0;
    total++;
    if (Halted !== 1'b1 || IrValid !== 1'b0) begin
      bad++;
      $display("FAIL halted: H=%b V=%b want 1 0", Halted, IrValid);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (PcUp !== 1'b0 || PcAddr !== 7'd4 || Halted !== 1'b1) begin
        bad++;
        $display("FAIL done_idle_%0d: Up=%b pc=%0d H=%b want 0 4 1", i, PcUp, PcAddr, Halted);
      end
    end
    Start = 1'b1;
    tick;
    Start = 1'b0;
    total++;
    if (Halted !== 1'b0 || PcClr !== 1'b1) begin
      bad++;
      $display("FAIL restart: H=%b Clr=%b want 0 1", Halted, PcClr);
    end
    repeat (3) tick;
    total++;
    if (IrValid !== 1'b1 || IR !== 16'h1234 || IrAddr !== 7'd0) begin
      bad++;
      $display("FAIL restart_ir: V=%b IR=%h addr=%0d want 1 1234 0", IrValid, IR, IrAddr);
    end
    Start = 1'b1;
    tick;
    Start = 1'b0;
    total++;
    if (IrValid !== 1'b1 || PcClr !== 1'b0 || PcUp !== 1'b0) begin
      bad++;
      $display("FAIL start_in_hold: V=%b Clr=%b Up=%b want 1 0 0", IrValid, PcClr, PcUp);
    end
  endtask

  task automatic test_flush;
    Flush   = 1'b1;
    Start   = 1'b1;
    IrReady = 1'b1;
    tick;
    Flush   = 1'b0;
    Start   = 1'b0;
    IrReady = 1'b0;
    total++;
    if ({IrValid, Halted, PcUp, PcClr} !== 4'b0000 || IR !== 16'h1234 || IrAddr !== 7'd0 ||
        PcAddr !== 7'd1) begin
      bad++;
      $display("FAIL flush: V=%b H=%b Up=%b Clr=%b IR=%h addr=%0d pc=%0d want 0 0 0 0 1234 0 1",
               IrValid, Halted, PcUp, PcClr, IR, IrAddr, PcAddr);
    end
    tick;
    total++;
    if ({IrValid, PcUp, PcClr} !== 3'b000) begin
      bad++;
      $display("FAIL flush_idle: V/Up/Clr=%b%b%b want 000", IrValid, PcUp, PcClr);
    end
  endtask

  task automatic test_reset_mid;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    tick;
    tick;  // CAPTURE
    total++;
    if (PcUp !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_capture: Up=%b want 1", PcUp);
    end
    #3;
    Reset = 1'b1;
    #1;
    total++;
    if ({IrValid, Halted, PcUp, PcClr} !== 4'b0000 || IR !== 16'h0) begin
      bad++;
      $display("FAIL async_reset: V=%b H=%b Up=%b Clr=%b IR=%h want 0 0 0 0 0000",
               IrValid, Halted, PcUp, PcClr, IR);
    end
    tick;
    Reset = 1'b0;
    tick;
    total++;
    if ({IrValid, PcUp, PcClr} !== 3'b000) begin
      bad++;
      $display("FAIL post_reset_idle: V/Up/Clr=%b%b%b want 000", IrValid, PcUp, PcClr);
    end
    Start = 1'b1;
    tick;
    Start = 1'b0;
    repeat (3) tick;
    total++;
    if (IrValid !== 1'b1 || IR !== 16'h1234 || IrAddr !== 7'd0) begin
      bad++;
      $display("FAIL post_reset_fetch: V=%b IR=%h addr=%0d want 1 1234 0", IrValid, IR, IrAddr);
    end
  endtask

  task automatic test_full_range;
    int            got;
    int            n;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    got = 0;
    n   = 0;
    ea  = '0;
    // Every word carries the halt opcode, which this instance must ignore.
    for (int i = 0; i < 128; i++) mem[i] = {4'hF, 5'd0, i[6:0]};
    Start2 = 1'b1;
    tick;
    Start2   = 1'b0;
    IrReady2 = 1'b1;
    while (Halted2 !== 1'b1 && n < 600) begin
      if (IrValid2 === 1'b1) begin
        ew = {4'hF, 5'd0, ea};
        total++;
        if (IrAddr2 !== ea || IR2 !== ew) begin
          bad++;
          $display("FAIL range_word: addr=%0d IR=%h want %0d %h", IrAddr2, IR2, ea, ew);
        end
        ea++;
        got++;
      end
      tick;
      n++;
    end
    IrReady2 = 1'b0;
    total++;
    if (got !== 128) begin
      bad++;
      $display("FAIL range_count: got %0d instructions want 128", got);
    end
    total++;
    if (Halted2 !== 1'b1 || IrAddr2 !== 7'd127 || PcAddr2 !== 7'd127 || IrValid2 !== 1'b0) begin
      bad++;
      $display("FAIL range_end: H=%b addr=%0d pc=%0d V=%b want 1 127 127 0",
               Halted2, IrAddr2, PcAddr2, IrValid2);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    Flush    = 1'b0;
    IrReady  = 1'b0;
    Start2   = 1'b0;
    IrReady2 = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    mem[2] = 16'h5678;
    mem[3] = 16'hF000;

    test_reset;
    test_first_fetch;
    test_stall;
    test_halt;
    test_flush;
    test_reset_mid;
    test_full_range;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
